level_meter_ctrl: RTL and testbench

Level-meter controller that sits between the ADC sample stream and the LED bar-graph driver. It converts offset-binary 12-bit samples to magnitudes, tracks the maximum over a fixed window of samples, and publishes one level per window (about 86 Hz at 44100 samples/s with WINDOW=512). It also runs a peak-hold/decay tracker. The `level` or `peak` output drives the LED driver's 12-bit magnitude input directly; only bits 10:3 are significant there, and bit 11 is always 0.

---
 rtl/level_meter_ctrl.sv | 65 ++++++
 tb/tb_level_meter_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/level_meter_ctrl.sv
// level_meter_ctrl: windowed max-magnitude level meter with peak-hold/decay tracker for an LED bar graph
module level_meter_ctrl #(
    parameter int WINDOW       = 512,
    parameter int HOLD_WINDOWS = 16,
    parameter int DECAY_STEP   = 64
) (
    input  logic        dclk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    input  logic        clear,
    output logic [11:0] level,
    output logic        level_valid,
    output logic [11:0] peak
);
    localparam int CW = $clog2(WINDOW);

    logic [CW-1:0] cnt, cnt_n;
    logic [10:0]   win_max, win_n, mag, new_max, pk, pk_n, lvl, lvl_n, dec;
    logic [7:0]    hold, hold_n;
    logic [12:0]   diff;
    logic          last, publish;

    always_comb begin
        diff    = sample[11] ? {2'b0, sample[10:0]} : 13'd2048 - {1'b0, sample};
        mag     = diff > 13'd2047 ? 11'd2047 : diff[10:0];
        new_max = mag > win_max ? mag : win_max;
        last    = cnt == CW'(WINDOW - 1);
        publish = sample_valid && last;
        dec     = pk >= 11'(DECAY_STEP) ? pk - 11'(DECAY_STEP) : 11'd0;
        cnt_n   = sample_valid ? (last ? '0 : cnt + 1'b1) : cnt;
        win_n   = sample_valid ? (last ? 11'd0 : new_max) : win_max;
        lvl_n   = publish ? new_max : lvl;
        // decay never drops the peak below the level just published
        pk_n    = !publish ? pk : new_max >= pk ? new_max : hold != 8'd0 ? pk : dec > new_max ? dec : new_max;
        hold_n  = !publish ? hold : new_max >= pk ? 8'(HOLD_WINDOWS) : hold != 8'd0 ? hold - 1'b1 : hold;
    end

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            win_max     <= '0;
            lvl         <= '0;
            pk          <= '0;
            hold        <= '0;
            level_valid <= 1'b0;
        end else if (clear) begin
            cnt         <= '0;
            win_max     <= '0;
            pk          <= '0;
            hold        <= '0;
            level_valid <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            win_max     <= win_n;
            lvl         <= lvl_n;
            pk          <= pk_n;
            hold        <= hold_n;
            level_valid <= publish;
        end
    end

    assign level = {1'b0, lvl};
    assign peak  = {1'b0, pk};
endmodule

// File: tb/tb_level_meter_ctrl.sv
// tb_level_meter_ctrl: directed checks of level_meter_ctrl with WINDOW=4, HOLD_WINDOWS=2, DECAY_STEP=64
module tb_level_meter_ctrl;
    logic        dclk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] sample = 12'd2048;
    logic        clear = 1'b0;
    logic [11:0] level, peak;
    logic        level_valid;
    int          total = 0;
    int          bad = 0;

    level_meter_ctrl #(.WINDOW(4), .HOLD_WINDOWS(2), .DECAY_STEP(64)) dut (
        .dclk(dclk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .clear(clear), .level(level), .level_valid(level_valid), .peak(peak)
    );

    always #5 dclk = ~dclk;

    task automatic push(input logic [11:0] s);
        sample_valid = 1'b1;
        sample = s;
        @(posedge dclk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge dclk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge dclk);
        rst = 1'b1;
        @(negedge dclk);
        rst = 1'b0;
        #2;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (level !== 12'd0 || peak !== 12'd0 || level_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_init level=%0d peak=%0d lv=%0b exp 0/0/0", level, peak, level_valid);
        end
        @(negedge dclk);
        rst = 1'b0;
        #2;
        push(12'd2548); push(12'd2048); push(12'd2048); push(12'd2048);
        total++;
        if (level_valid !== 1'b1 || level !== 12'd500) begin
            bad++;
            $display("FAIL reset_prewin lv=%0b level=%0d exp 1/500", level_valid, level);
        end
        push(12'd3000); push(12'd3000);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (level !== 12'd0 || peak !== 12'd0 || level_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_async level=%0d peak=%0d lv=%0b exp 0/0/0", level, peak, level_valid);
        end
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(12'd3048);
            total++;
            if (level_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_early_pulse idx=%0d lv=%0b exp 0", i, level_valid);
            end
        end
        push(12'd2048);
        total++;
        if (level_valid !== 1'b1 || level !== 12'd1000 || peak !== 12'd1000) begin
            bad++;
            $display("FAIL reset_newwin lv=%0b level=%0d peak=%0d exp 1/1000/1000", level_valid, level, peak);
        end
    endtask

    task automatic test_basic();
        logic [11:0] v [4] = '{12'd2048, 12'd2100, 12'd1900, 12'd2048};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            push(v[i]);
            total++;
            if (level_valid !== 1'b0) begin
                bad++;
                $display("FAIL basic_early idx=%0d lv=%0b exp 0", i, level_valid);
            end
        end
        push(v[3]);
        total++;
        if (level_valid !== 1'b1 || level !== 12'd148 || peak !== 12'd148) begin
            bad++;
            $display("FAIL basic_publish lv=%0b level=%0d peak=%0d exp 1/148/148", level_valid, level, peak);
        end
        idle();
        total++;
        if (level_valid !== 1'b0 || level !== 12'd148) begin
            bad++;
            $display("FAIL basic_after lv=%0b level=%0d exp 0/148", level_valid, level);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        push(12'd0); push(12'd4095); push(12'd2048); push(12'd2048);
        total++;
        if (level_valid !== 1'b1 || level !== 12'd2047 || level[11] !== 1'b0) begin
            bad++;
            $display("FAIL sat_level lv=%0b level=%0d exp 1/2047", level_valid, level);
        end
        push(12'd2047); push(12'd2049); push(12'd2048); push(12'd2048);
        total++;
        if (level_valid !== 1'b1 || level !== 12'd1 || peak !== 12'd2047) begin
            bad++;
            $display("FAIL sign_level lv=%0b level=%0d peak=%0d exp 1/1/2047", level_valid, level, peak);
        end
    endtask

    task automatic test_hold_decay();
        int exp_pk;
        apply_reset();
        push(12'd3048); push(12'd2048); push(12'd2048); push(12'd2048);
        total++;
        if (level_valid !== 1'b1 || level !== 12'd1000 || peak !== 12'd1000) begin
            bad++;
            $display("FAIL hold_first lv=%0b level=%0d peak=%0d exp 1/1000/1000", level_valid, level, peak);
        end
        for (int w = 2; w <= 20; w++) begin
            for (int k = 0; k < 4; k++) push(12'd2048);
            exp_pk = (w <= 3) ? 1000 : 1000 - 64 * (w - 3);
            if (exp_pk < 0) exp_pk = 0;
            total++;
            if (level_valid !== 1'b1 || level !== 12'd0 || peak !== 12'(exp_pk)) begin
                bad++;
                $display("FAIL hold_decay win=%0d lv=%0b level=%0d peak=%0d exp 1/0/%0d", w, level_valid, level, peak, exp_pk);
            end
        end
    endtask

    task automatic test_gaps_clear();
        apply_reset();
        push(12'd2548);
        for (int i = 0; i < 5; i++) idle();
        push(12'd2048); push(12'd2048);
        total++;
        if (level_valid !== 1'b0) begin
            bad++;
            $display("FAIL gap_early lv=%0b exp 0", level_valid);
        end
        push(12'd2048);
        total++;
        if (level_valid !== 1'b1 || level !== 12'd500 || peak !== 12'd500) begin
            bad++;
            $display("FAIL gap_publish lv=%0b level=%0d peak=%0d exp 1/500/500", level_valid, level, peak);
        end
        push(12'd3048);
        clear = 1'b1;
        push(12'd4000);
        clear = 1'b0;
        total++;
        if (level_valid !== 1'b0 || peak !== 12'd0 || level !== 12'd500) begin
            bad++;
            $display("FAIL clear_state lv=%0b level=%0d peak=%0d exp 0/500/0", level_valid, level, peak);
        end
        push(12'd2148); push(12'd2048); push(12'd2048);
        total++;
        if (level_valid !== 1'b0) begin
            bad++;
            $display("FAIL clear_early lv=%0b exp 0", level_valid);
        end
        push(12'd2048);
        total++;
        if (level_valid !== 1'b1 || level !== 12'd100 || peak !== 12'd100) begin
            bad++;
            $display("FAIL clear_newwin lv=%0b level=%0d peak=%0d exp 1/100/100", level_valid, level, peak);
        end
    endtask

    task automatic test_decay_floor();
        apply_reset();
        push(12'd3048); push(12'd2048); push(12'd2048); push(12'd2048);
        for (int i = 0; i < 8; i++) push(12'd2048);
        total++;
        if (peak !== 12'd1000) begin
            bad++;
            $display("FAIL floor_held peak=%0d exp 1000", peak);
        end
        push(12'd3028); push(12'd2048); push(12'd2048); push(12'd2048);
        total++;
        if (level_valid !== 1'b1 || level !== 12'd980 || peak !== 12'd980) begin
            bad++;
            $display("FAIL floor_peak lv=%0b level=%0d peak=%0d exp 1/980/980", level_valid, level, peak);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_hold_decay();
        test_gaps_clear();
        test_decay_floor();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
